// File: rtl/sram_controller.sv
// sram_controller: MEM-stage word access over a 16-bit asynchronous SRAM.
// Each 32-bit access is split into two half-word accesses, low half first.
// Each half is held for WAIT_CYCLES cycles.
//
// Optional macro SRAM_LAST_WORD_HIT_EN adds a one-entry last-word tag.
// A read of the most recently completed word then completes in the
// request cycle and does not touch the SRAM.
//
// Ports:
//   i_clk, i_rst              : clock and synchronous active-high reset.
//   i_rd_en / i_wr_en         : requests, held by the MEM stage until o_ready.
//   i_address, i_write_data   : byte address and store data.
//   o_read_data               : registered load result.
//   o_ready                   : access complete, or no access pending.
//   o_sram_*, i_sram_dq_in    : SRAM pins. The top level builds the inout
//                               bus from o_sram_dq_out and o_sram_dq_oe.
module sram_controller #(
  parameter logic [31:0] BASE_ADDR   = 32'd1024,
  parameter int unsigned WAIT_CYCLES = 2
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_rd_en,
  input  logic        i_wr_en,
  input  logic [31:0] i_address,
  input  logic [31:0] i_write_data,
  output logic [31:0] o_read_data,
  output logic        o_ready,
  output logic [17:0] o_sram_addr,
  output logic [15:0] o_sram_dq_out,
  input  logic [15:0] i_sram_dq_in,
  output logic        o_sram_dq_oe,
  output logic        o_sram_we_n,
  output logic        o_sram_oe_n
);

  typedef enum logic [1:0] {S_IDLE, S_LOW, S_HIGH, S_DONE} state_t;

  localparam logic [3:0] LAST = 4'(WAIT_CYCLES - 1);

  state_t      r_state, w_state_nxt;
  logic [3:0]  r_cnt, w_cnt_nxt;
  logic        r_op_wr;
  logic [16:0] r_word;
  logic [31:0] r_wdata;
  logic [31:0] r_read_data;
  logic [17:0] r_sram_addr;
  logic [15:0] r_sram_dq_out;
  logic        r_sram_dq_oe, r_sram_we_n, r_sram_oe_n;

  logic [31:0] w_offset;
  logic [16:0] w_word_in;
  logic        w_req, w_hit, w_last;
  logic        w_op_wr_nxt, w_last_nxt;
  logic [16:0] w_word_nxt;
  logic [31:0] w_wdata_nxt;
  logic [17:0] w_addr_nxt;
  logic [15:0] w_dq_out_nxt;
  logic        w_dq_oe_nxt, w_we_n_nxt, w_oe_n_nxt;

  // Out-of-range addresses wrap silently, with no range check.
  assign w_offset  = i_address - BASE_ADDR;
  assign w_word_in = 17'(w_offset >> 2);
  assign w_req     = i_rd_en | i_wr_en;
  assign w_last    = (r_cnt == LAST);

`ifdef SRAM_LAST_WORD_HIT_EN
  logic [16:0] r_tag;
  logic        r_tag_vld;
  assign w_hit = (r_state == S_IDLE) && i_rd_en && !i_wr_en && r_tag_vld && (r_tag == w_word_in);
`else
  assign w_hit = 1'b0;
`endif

  assign o_ready = ((r_state == S_IDLE) && !w_req) || (r_state == S_DONE) || w_hit;

  // When leaving IDLE, the request is not latched yet.
  // The next-cycle pin values must therefore come straight from the inputs.
  assign w_op_wr_nxt = (r_state == S_IDLE) ? i_wr_en      : r_op_wr;
  assign w_word_nxt  = (r_state == S_IDLE) ? w_word_in    : r_word;
  assign w_wdata_nxt = (r_state == S_IDLE) ? i_write_data : r_wdata;

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    case (r_state)
      S_IDLE: if (w_req && !w_hit) begin w_state_nxt = S_LOW;  w_cnt_nxt = 4'd0; end
      S_LOW:  if (w_last) begin w_state_nxt = S_HIGH; w_cnt_nxt = 4'd0; end
              else w_cnt_nxt = r_cnt + 4'd1;
      S_HIGH: if (w_last) begin w_state_nxt = S_DONE; w_cnt_nxt = 4'd0; end
              else w_cnt_nxt = r_cnt + 4'd1;
      default: begin w_state_nxt = S_IDLE; w_cnt_nxt = 4'd0; end
    endcase
  end

  // The pins are registered, so they are derived from the next state and counter.
  // This lines up each pin value with the state it belongs to.
  always_comb begin
    w_last_nxt   = (w_cnt_nxt == LAST);
    w_addr_nxt   = r_sram_addr;
    w_dq_out_nxt = r_sram_dq_out;
    w_dq_oe_nxt  = 1'b0;
    w_we_n_nxt   = 1'b1;
    w_oe_n_nxt   = 1'b1;
    if (w_state_nxt == S_LOW || w_state_nxt == S_HIGH) begin
      w_addr_nxt = {w_word_nxt, (w_state_nxt == S_HIGH)};
      if (w_op_wr_nxt) begin
        w_dq_oe_nxt  = 1'b1;
        // The strobe is released on the last cycle of the phase so that data is held.
        w_we_n_nxt   = w_last_nxt;
        w_dq_out_nxt = (w_state_nxt == S_HIGH) ? w_wdata_nxt[31:16] : w_wdata_nxt[15:0];
      end else begin
        w_oe_n_nxt = 1'b0;
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state       <= S_IDLE;
      r_cnt         <= 4'd0;
      r_op_wr       <= 1'b0;
      r_word        <= 17'd0;
      r_wdata       <= 32'd0;
      r_read_data   <= 32'd0;
      r_sram_addr   <= 18'd0;
      r_sram_dq_out <= 16'd0;
      r_sram_dq_oe  <= 1'b0;
      r_sram_we_n   <= 1'b1;
      r_sram_oe_n   <= 1'b1;
`ifdef SRAM_LAST_WORD_HIT_EN
      r_tag         <= 17'd0;
      r_tag_vld     <= 1'b0;
`endif
    end else begin
      r_state       <= w_state_nxt;
      r_cnt         <= w_cnt_nxt;
      r_sram_addr   <= w_addr_nxt;
      r_sram_dq_out <= w_dq_out_nxt;
      r_sram_dq_oe  <= w_dq_oe_nxt;
      r_sram_we_n   <= w_we_n_nxt;
      r_sram_oe_n   <= w_oe_n_nxt;
      if (r_state == S_IDLE && w_req && !w_hit) begin
        // When both enables are high, the access is a write.
        r_op_wr <= i_wr_en;
        r_word  <= w_word_in;
        r_wdata <= i_write_data;
      end
      if (!r_op_wr && w_last) begin
        if (r_state == S_LOW)  r_read_data[15:0]  <= i_sram_dq_in;
        if (r_state == S_HIGH) r_read_data[31:16] <= i_sram_dq_in;
      end
`ifdef SRAM_LAST_WORD_HIT_EN
      if (r_state == S_HIGH && w_last) begin
        r_tag     <= r_word;
        r_tag_vld <= 1'b1;
        if (r_op_wr) r_read_data <= r_wdata;
      end
`endif
    end
  end

  assign o_read_data   = r_read_data;
  assign o_sram_addr   = r_sram_addr;
  assign o_sram_dq_out = r_sram_dq_out;
  assign o_sram_dq_oe  = r_sram_dq_oe;
  assign o_sram_we_n   = r_sram_we_n;
  assign o_sram_oe_n   = r_sram_oe_n;

endmodule

// File: tb/tb_sram_controller.sv
// Testbench for sram_controller with BASE_ADDR=1024 and WAIT_CYCLES=2.
// It contains a behavioural SRAM and a word-level reference model.
// Define SRAM_LAST_WORD_HIT_EN to exercise the last-word tag build.
module tb_sram_controller;
  localparam int W   = 2;
  localparam int LAT = 2 * W + 1;
`ifdef SRAM_LAST_WORD_HIT_EN
  localparam bit HIT = 1'b1;
`else
  localparam bit HIT = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst, rd_en, wr_en;
  logic [31:0] address, write_data, read_data;
  logic        ready;
  logic [17:0] sram_addr;
  logic [15:0] sram_dq_out, sram_dq_in;
  logic        sram_dq_oe, sram_we_n, sram_oe_n;

  always #5 clk = ~clk;

  sram_controller #(.BASE_ADDR(32'd1024), .WAIT_CYCLES(W)) dut (
    .i_clk(clk), .i_rst(rst), .i_rd_en(rd_en), .i_wr_en(wr_en),
    .i_address(address), .i_write_data(write_data),
    .o_read_data(read_data), .o_ready(ready),
    .o_sram_addr(sram_addr), .o_sram_dq_out(sram_dq_out), .i_sram_dq_in(sram_dq_in),
    .o_sram_dq_oe(sram_dq_oe), .o_sram_we_n(sram_we_n), .o_sram_oe_n(sram_oe_n)
  );

  // Behavioural SRAM.
  logic [15:0] sram [0:262143];
  assign sram_dq_in = sram_oe_n ? 16'h0000 : sram[sram_addr];
  always @(posedge clk) if (!sram_we_n && sram_dq_oe) sram[sram_addr] <= sram_dq_out;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Reference model: the contents of each word, the last loaded value, and the last completed word.
  logic [31:0] ref_mem [int];
  logic [31:0] m_rd = 32'h0;
  logic [16:0] m_tag = 17'h0;
  bit          m_tag_vld = 1'b0;

  function automatic logic [16:0] word_of(input logic [31:0] a);
    return 17'((a - 32'd1024) / 4);
  endfunction

  task automatic model_step(input bit rd, input bit wr, input logic [31:0] a, input logic [31:0] wd,
                            output logic [31:0] exp_rd, output int exp_lat);
    logic [16:0] w;
    w = word_of(a);
    exp_lat = LAT;
    if (wr) begin
      ref_mem[int'(w)] = wd;
      if (HIT) begin m_rd = wd; m_tag = w; m_tag_vld = 1'b1; end
    end else if (rd) begin
      if (HIT && m_tag_vld && m_tag == w) exp_lat = 0;
      if (HIT) begin m_tag = w; m_tag_vld = 1'b1; end
      m_rd = ref_mem.exists(int'(w)) ? ref_mem[int'(w)] : 32'h0;
    end
    exp_rd = m_rd;
  endtask

  task automatic model_reset();
    m_rd = 32'h0;
    m_tag_vld = 1'b0;
  endtask

  // Runs one request until ready and records what happens on the SRAM pins.
  task automatic run_check(input string name, input bit rd, input bit wr, input logic [31:0] a,
                           input logic [31:0] wd, input int drop_at,
                           input logic [31:0] exp_rd, input int exp_lat);
    logic [16:0] w;
    int lat, we_cnt, oe_cnt, dqoe_cnt, bad;
    bit done, seen_hi;
    w = word_of(a);
    lat = 0; we_cnt = 0; oe_cnt = 0; dqoe_cnt = 0; bad = 0; done = 0; seen_hi = 0;
    @(posedge clk); #1;
    rd_en = rd; wr_en = wr; address = a; write_data = wd;
    for (int c = 0; c < 100 && !done; c++) begin
      @(negedge clk);
      if (ready) done = 1;
      else begin
        lat++;
        if (sram_dq_oe) dqoe_cnt++;
        if (!sram_we_n) begin
          we_cnt++;
          if (sram_addr[17:1] !== w || !sram_dq_oe || !sram_oe_n ||
              sram_dq_out !== (sram_addr[0] ? wd[31:16] : wd[15:0])) bad++;
        end
        if (!sram_oe_n) begin
          oe_cnt++;
          if (sram_addr[17:1] !== w || sram_dq_oe) bad++;
        end
        if (!sram_we_n || !sram_oe_n) begin
          if (seen_hi && !sram_addr[0]) bad++;
          if (sram_addr[0]) seen_hi = 1;
        end
        @(posedge clk); #1;
        if (drop_at > 0 && lat == drop_at) begin rd_en = 0; wr_en = 0; end
      end
    end
    chk({name, "_timeout"}, 32'(done), 32'd1);
    chk({name, "_lat"}, lat, exp_lat);
    chk({name, "_rdata"}, read_data, exp_rd);
    chk({name, "_done_pins"}, {29'd0, sram_we_n, sram_oe_n, sram_dq_oe}, 32'd6);
    chk({name, "_strobe_bad"}, bad, 0);
    @(posedge clk); #1;
    rd_en = 0; wr_en = 0;
    if (exp_lat == 0) begin
      chk({name, "_hit_strobes"}, we_cnt + oe_cnt + dqoe_cnt, 0);
    end else if (wr) begin
      chk({name, "_we_cnt"}, we_cnt, 2 * (W - 1));
      chk({name, "_oe_cnt"}, oe_cnt, 0);
      chk({name, "_dqoe_cnt"}, dqoe_cnt, 2 * W);
      chk({name, "_mem"}, {sram[{w, 1'b1}], sram[{w, 1'b0}]}, wd);
    end else begin
      chk({name, "_oe_cnt"}, oe_cnt, 2 * W);
      chk({name, "_we_cnt"}, we_cnt + dqoe_cnt, 0);
    end
  endtask

  typedef struct {
    bit          rd;
    bit          wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp_rd;
    int          exp_lat;
  } vec_t;

  vec_t tbl [5];
  logic [31:0] pool [10];

  initial begin
    logic [31:0] e_rd, a, wd;
    int e_lat, op, drop, bad;
    bit rd, wr;

    tbl[0] = '{1'b0, 1'b1, 32'd1032, 32'hDEADBEEF, HIT ? 32'hDEADBEEF : 32'h0, LAT};
    tbl[1] = '{1'b1, 1'b0, 32'd1032, 32'h0,        32'hDEADBEEF, HIT ? 0 : LAT};
    tbl[2] = '{1'b1, 1'b1, 32'd1024, 32'h12345678, HIT ? 32'h12345678 : 32'hDEADBEEF, LAT};
    tbl[3] = '{1'b1, 1'b0, 32'd1024, 32'h0,        32'h12345678, HIT ? 0 : LAT};
    tbl[4] = '{1'b1, 1'b0, 32'd1032, 32'h0,        32'hDEADBEEF, LAT};

    rst = 1; rd_en = 0; wr_en = 0; address = 0; write_data = 0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_ready", 32'(ready), 32'd1);
    chk("rst_pins", {29'd0, sram_we_n, sram_oe_n, sram_dq_oe}, 32'd6);
    chk("rst_addr", 32'(sram_addr), 32'd0);
    chk("rst_dq_out", 32'(sram_dq_out), 32'd0);
    chk("rst_rdata", read_data, 32'd0);
    @(posedge clk); #1 rst = 0;

    for (int i = 0; i < 5; i++) begin
      model_step(tbl[i].rd, tbl[i].wr, tbl[i].addr, tbl[i].wdata, e_rd, e_lat);
      run_check($sformatf("vec%0d", i), tbl[i].rd, tbl[i].wr, tbl[i].addr, tbl[i].wdata, 0,
                tbl[i].exp_rd, tbl[i].exp_lat);
    end

    // The request is dropped after the first LOW cycle. The access still completes, and no second access follows.
    model_step(1'b1, 1'b0, 32'd1024, 32'h0, e_rd, e_lat);
    run_check("drop", 1'b1, 1'b0, 32'd1024, 32'h0, 2, 32'h12345678, LAT);
    bad = 0;
    repeat (4) begin
      @(negedge clk);
      if (!ready || !sram_oe_n || !sram_we_n) bad++;
    end
    chk("drop_idle_after", bad, 0);

`ifdef SRAM_LAST_WORD_HIT_EN
    model_step(1'b0, 1'b1, 32'd1044, 32'h0BADF00D, e_rd, e_lat);
    run_check("hit_w1044", 1'b0, 1'b1, 32'd1044, 32'h0BADF00D, 0, 32'h0BADF00D, LAT);
    model_step(1'b0, 1'b1, 32'd1040, 32'hCAFEF00D, e_rd, e_lat);
    run_check("hit_w1040", 1'b0, 1'b1, 32'd1040, 32'hCAFEF00D, 0, 32'hCAFEF00D, LAT);
    model_step(1'b1, 1'b0, 32'd1040, 32'h0, e_rd, e_lat);
    run_check("hit_r1040", 1'b1, 1'b0, 32'd1040, 32'h0, 0, 32'hCAFEF00D, 0);
    model_step(1'b1, 1'b0, 32'd1044, 32'h0, e_rd, e_lat);
    run_check("hit_r1044", 1'b1, 1'b0, 32'd1044, 32'h0, 0, 32'h0BADF00D, LAT);
    @(posedge clk); #1 rst = 1;
    @(posedge clk); #1 rst = 0;
    model_reset();
    model_step(1'b1, 1'b0, 32'd1040, 32'h0, e_rd, e_lat);
    run_check("hit_rst_r1040", 1'b1, 1'b0, 32'd1040, 32'h0, 0, 32'hCAFEF00D, LAT);
`endif

    // Reset is asserted during the HIGH phase of a write.
    @(posedge clk); #1;
    wr_en = 1; address = 32'd1060; write_data = 32'hAAAA5555;
    repeat (3) @(posedge clk);
    #1 rst = 1; wr_en = 0;
    @(posedge clk);
    @(negedge clk);
    chk("midrst_ready", 32'(ready), 32'd1);
    chk("midrst_pins", {29'd0, sram_we_n, sram_oe_n, sram_dq_oe}, 32'd6);
    chk("midrst_rdata", read_data, 32'd0);
    @(posedge clk); #1 rst = 0;
    model_reset();
    ref_mem.delete(int'(word_of(32'd1060)));
    @(negedge clk);
    chk("midrst_idle", 32'(ready), 32'd1);

    // Random traffic is checked against the reference model.
    for (int k = 0; k < 8; k++) pool[k] = 32'd1024 + 32'(4 * k);
    pool[8] = 32'd0;
    pool[9] = 32'hFFFFFFFC;
    for (int n = 0; n < 40; n++) begin
      a  = pool[$urandom_range(0, 9)];
      wd = $urandom;
      op = $urandom_range(0, 2);
      rd = (op != 1);
      wr = (op != 0);
      if (!wr && !ref_mem.exists(int'(word_of(a)))) begin rd = 0; wr = 1; end
      drop = ($urandom_range(0, 1) == 1) ? $urandom_range(2, 4) : 0;
      model_step(rd, wr, a, wd, e_rd, e_lat);
      run_check($sformatf("rnd%0d", n), rd, wr, a, wd, drop, e_rd, e_lat);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
